// File: rtl/pixel_raster_pkg.sv
// Shared widths, board limits, FSM state and command record for the
// pixel raster queue.
package pixel_raster_pkg;

  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COLOUR_W = 3;

  localparam int unsigned X_MAX_DEF = 159;
  localparam int unsigned Y_MAX_DEF = 119;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

  // 33-bit queued draw command; w/h are extents minus one
  typedef struct packed {
    logic [X_W-1:0]      x0;
    logic [Y_W-1:0]      y0;
    logic [X_W-1:0]      w;
    logic [Y_W-1:0]      h;
    logic [COLOUR_W-1:0] colour;
  } cmd_t;

endpackage

// File: rtl/pixel_raster_queue_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate counter.
module cmd_fifo
  import pixel_raster_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  cmd_t din,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  cmd_t        mem [DEPTH];
  logic        push_ok;
  logic        pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pixel_raster_queue.sv
// Queued pixel/rectangle draw engine: clips each command to the board and
// rasterises it row-major at one pixel per clock for the VGA adapter.
module pixel_raster_queue
  import pixel_raster_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned X_MAX      = X_MAX_DEF,
  parameter int unsigned Y_MAX      = Y_MAX_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [X_W-1:0]      cmd_x0,
  input  logic [Y_W-1:0]      cmd_y0,
  input  logic [X_W-1:0]      cmd_w,
  input  logic [Y_W-1:0]      cmd_h,
  input  logic [COLOUR_W-1:0] cmd_colour,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy
);

  localparam logic [X_W:0] X_LIM = (X_W+1)'(X_MAX);
  localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(Y_MAX);

  state_t state, state_n;
  cmd_t   cmd_in, head;
  logic   full, empty;
  logic   push, pop, load;
  logic   on_screen, last;

  logic [X_W:0]          x_sum;
  logic [Y_W:0]          y_sum;
  logic [X_W-1:0]        x_end_n;
  logic [Y_W-1:0]        y_end_n;
  logic [X_W-1:0]        cx, x_start, x_end;
  logic [Y_W-1:0]        cy, y_end;
  logic [COLOUR_W-1:0]   col;

  assign cmd_in = '{x0: cmd_x0, y0: cmd_y0, w: cmd_w, h: cmd_h, colour: cmd_colour};
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (cmd_in),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Extra carry bit keeps x0+w / y0+h from wrapping before the clamp
  assign x_sum     = {1'b0, head.x0} + {1'b0, head.w};
  assign y_sum     = {1'b0, head.y0} + {1'b0, head.h};
  assign x_end_n   = (x_sum > X_LIM) ? X_LIM[X_W-1:0] : x_sum[X_W-1:0];
  assign y_end_n   = (y_sum > Y_LIM) ? Y_LIM[Y_W-1:0] : y_sum[Y_W-1:0];
  assign on_screen = ({1'b0, head.x0} <= X_LIM) && ({1'b0, head.y0} <= Y_LIM);
  assign last      = (cx == x_end) && (cy == y_end);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (on_screen) begin
            load    = 1'b1;
            state_n = DRAW;
          end
        end
      end
      DRAW: begin
        if (last) begin
          if (!empty) begin
            pop = 1'b1;
            if (on_screen) load    = 1'b1;
            else           state_n = IDLE;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    plot   = (state == DRAW);
    busy   = (state == DRAW) || !empty;
    x      = cx;
    y      = cy;
    colour = col;
  end

  // Counters hold after the final pixel so x/y/colour keep their last value in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cx      <= '0;
      cy      <= '0;
      x_start <= '0;
      x_end   <= '0;
      y_end   <= '0;
      col     <= '0;
    end else if (load) begin
      cx      <= head.x0;
      cy      <= head.y0;
      x_start <= head.x0;
      x_end   <= x_end_n;
      y_end   <= y_end_n;
      col     <= head.colour;
    end else if (state == DRAW && !last) begin
      if (cx == x_end) begin
        cx <= x_start;
        cy <= cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

endmodule
